// File: rtl/hex_led_arbiter.sv
// Two-requester arbiter for the 6-digit hex display with a minimum dwell per owner.
// Optional leading-zero blanking of hex_blank is enabled by defining HEX_LZB_EN.
module hex_led_arbiter #(
   parameter int DIGITS      = 6,
   parameter int HOLD_CYCLES = 50000000,
   parameter int CNT_WIDTH   = 26
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req0_valid,
   input  logic [4*DIGITS-1:0]   req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [4*DIGITS-1:0]   req1_data,
   output logic                  req1_ready,
   output logic [4*DIGITS-1:0]   hex_led,
   output logic [DIGITS-1:0]     hex_blank,
   output logic                  owner,
   output logic                  busy
);

   localparam int DW = 4*DIGITS;
   localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      OPEN  = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] counter;
   logic                 xfer0;
   logic                 xfer1;
   logic                 xfer_any;
   logic [DW-1:0]        xfer_data;

   // In OPEN the non-owner wins ties so a waiting source is never starved.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = 1'b1;
            req1_ready = ~req0_valid;
         end
         DWELL: begin
            req0_ready = ~owner;
            req1_ready = owner;
         end
         OPEN: begin
            if (owner) begin
               req0_ready = 1'b1;
               req1_ready = ~req0_valid;
            end else begin
               req1_ready = 1'b1;
               req0_ready = ~req1_valid;
            end
         end
         default: begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
         end
      endcase
   end

   assign xfer0     = req0_valid & req0_ready;
   assign xfer1     = req1_valid & req1_ready;
   assign xfer_any  = xfer0 | xfer1;
   assign xfer_data = xfer1 ? req1_data : req0_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         counter <= '0;
         hex_led <= '0;
         owner   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE, OPEN: begin
               if (xfer_any) begin
                  hex_led <= xfer_data;
                  owner   <= xfer1;
                  counter <= HOLD_LOAD;
                  state   <= DWELL;
                  busy    <= 1'b1;
               end
            end
            DWELL: begin
               // Owner writes refresh the value but never extend the dwell.
               if (xfer_any) begin
                  hex_led <= xfer_data;
               end
               if (counter == '0) begin
                  state <= OPEN;
                  busy  <= 1'b0;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef HEX_LZB_EN
   // Digit i is blanked when it and every more significant digit are zero; digit 0 always shows.
   function automatic logic [DIGITS-1:0] lzb_mask(input logic [DW-1:0] value);
      logic              run;
      logic [DIGITS-1:0] mask;
      run  = 1'b1;
      mask = '0;
      for (int unsigned i = DIGITS; i > 0; i--) begin
         run         = run & (value[4*(i-1) +: 4] == 4'h0);
         mask[i-1]   = run & (i != 1);
      end
      return mask;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_blank <= '0;
      end else if (xfer_any) begin
         hex_blank <= lzb_mask(xfer_data);
      end
   end
`else
   assign hex_blank = '0;
`endif

endmodule

// File: tb/tb_hex_led_arbiter.sv
// Self-checking bench for hex_led_arbiter with HOLD_CYCLES = 4: vector table plus scoreboard queue,
// and hand-written reset sequences. Blank-mask expectations follow HEX_LZB_EN.
module tb_hex_led_arbiter;

   logic        clk;
   logic        reset_n;
   logic        req0_valid;
   logic [23:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [23:0] req1_data;
   logic        req1_ready;
   logic [23:0] hex_led;
   logic [5:0]  hex_blank;
   logic        owner;
   logic        busy;

   int n_cmp;
   int n_err;

   hex_led_arbiter #(
      .DIGITS      (6),
      .HOLD_CYCLES (4),
      .CNT_WIDTH   (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .hex_led    (hex_led),
      .hex_blank  (hex_blank),
      .owner      (owner),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v0;
      logic [23:0] d0;
      logic        v1;
      logic [23:0] d1;
      logic        r0;
      logic        r1;
      logic [23:0] hex;
      logic        own;
      logic        bsy;
      logic [5:0]  blank;
   } vec_t;

   typedef struct packed {
      logic [23:0] hex;
      logic        own;
      logic        bsy;
      logic [5:0]  blank;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic add(input logic v0, input logic [23:0] d0, input logic v1, input logic [23:0] d1,
                      input logic r0, input logic r1, input logic [23:0] hex, input logic own,
                      input logic bsy, input logic [5:0] blank);
      vec_t v;
      v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
      v.r0 = r0; v.r1 = r1; v.hex = hex; v.own = own; v.bsy = bsy; v.blank = blank;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] exp_blank(input logic [5:0] b);
`ifdef HEX_LZB_EN
      return b;
`else
      return 6'b0 & b;
`endif
   endfunction

   task automatic drive(input logic v0, input logic [23:0] d0, input logic v1, input logic [23:0] d1);
      req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, time %0t limit 200000", $time);
      $fatal(1);
   end

   initial begin
      exp_t e;
      n_cmp = 0;
      n_err = 0;

      // Vectors start from IDLE right after reset; readies are checked before the edge,
      // hex_led/owner/busy/blank after it.
      add(1'b1, 24'h123456, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 24'h123456, 1'b0, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 24'h123456, 1'b0, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 24'h123456, 1'b0, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 24'h123456, 1'b0, 1'b1, 6'b000000);
      add(1'b1, 24'h654321, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 24'h654321, 1'b0, 1'b0, 6'b000000);
      add(1'b1, 24'h654321, 1'b1, 24'hABCDEF, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b1, 6'b000000);
      add(1'b1, 24'hC0FFEE, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b1, 6'b000000);
      add(1'b1, 24'hC0FFEE, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b1, 6'b000000);
      add(1'b1, 24'hC0FFEE, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b1, 6'b000000);
      add(1'b1, 24'hC0FFEE, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 6'b000000);
      add(1'b1, 24'hC0FFEE, 1'b0, 24'h000000, 1'b1, 1'b0, 24'hC0FFEE, 1'b0, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b1, 24'hBEEF00, 1'b1, 1'b0, 24'hC0FFEE, 1'b0, 1'b1, 6'b000000);
      add(1'b1, 24'h000111, 1'b1, 24'hBEEF00, 1'b1, 1'b0, 24'h000111, 1'b0, 1'b1, 6'b111000);
      add(1'b0, 24'h000000, 1'b1, 24'hBEEF00, 1'b1, 1'b0, 24'h000111, 1'b0, 1'b1, 6'b111000);
      add(1'b0, 24'h000000, 1'b1, 24'hBEEF00, 1'b1, 1'b0, 24'h000111, 1'b0, 1'b0, 6'b111000);
      add(1'b0, 24'h000000, 1'b1, 24'hBEEF00, 1'b0, 1'b1, 24'hBEEF00, 1'b1, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hBEEF00, 1'b1, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hBEEF00, 1'b1, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hBEEF00, 1'b1, 1'b1, 6'b000000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hBEEF00, 1'b1, 1'b0, 6'b000000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hBEEF00, 1'b1, 1'b0, 6'b000000);
      add(1'b0, 24'h000000, 1'b1, 24'h000A05, 1'b1, 1'b1, 24'h000A05, 1'b1, 1'b1, 6'b111000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'h000A05, 1'b1, 1'b1, 6'b111000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'h000A05, 1'b1, 1'b1, 6'b111000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'h000A05, 1'b1, 1'b1, 6'b111000);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 24'h000A05, 1'b1, 1'b0, 6'b111000);
      add(1'b1, 24'h000000, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 6'b111110);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 6'b111110);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 6'b111110);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 6'b111110);
      add(1'b0, 24'h000000, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 6'b111110);
      add(1'b1, 24'h5A5A5A, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h5A5A5A, 1'b0, 1'b1, 6'b000000);

      // Reset with idle inputs.
      reset_n = 1'b0;
      drive(1'b0, 24'h0, 1'b0, 24'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst hex_led", 32'(hex_led), 32'h0);
      chk("rst owner", 32'(owner), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst hex_blank", 32'(hex_blank), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst req0_ready", 32'(req0_ready), 32'h1);
      chk("rst req1_ready", 32'(req1_ready), 32'h1);

      // Table: tie, hand-over, owner update, idle OPEN, blank masks.
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
         #1;
         chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].r0));
         chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].r1));
         sb.push_back('{hex: vecs[i].hex, own: vecs[i].own, bsy: vecs[i].bsy,
                        blank: exp_blank(vecs[i].blank)});
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", i), 32'h1, 32'h0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d hex_led", i), 32'(hex_led), 32'(e.hex));
            chk($sformatf("v%0d owner", i), 32'(owner), 32'(e.own));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(e.bsy));
            chk($sformatf("v%0d hex_blank", i), 32'(hex_blank), 32'(e.blank));
         end
      end

      // Reset mid-DWELL while req1 waits: state clears at once and req1 is not taken.
      @(negedge clk);
      drive(1'b0, 24'h0, 1'b1, 24'hFACADE);
      #1;
      chk("md req1_ready dwell", 32'(req1_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("md hex_led dwell1", 32'(hex_led), 32'h5A5A5A);
      chk("md busy dwell1", 32'(busy), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("md hex_led reset", 32'(hex_led), 32'h0);
      chk("md owner reset", 32'(owner), 32'h0);
      chk("md busy reset", 32'(busy), 32'h0);
      chk("md hex_blank reset", 32'(hex_blank), 32'h0);
      chk("md req0_ready reset", 32'(req0_ready), 32'h1);
      chk("md req1_ready reset", 32'(req1_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("md hex_led held", 32'(hex_led), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 24'h0, 1'b0, 24'h0);
      @(posedge clk);
      #1;
      chk("md hex_led after", 32'(hex_led), 32'h0);
      chk("md busy after", 32'(busy), 32'h0);
      chk("md owner after", 32'(owner), 32'h0);
      @(negedge clk);
      drive(1'b0, 24'h0, 1'b1, 24'hFACADE);
      #1;
      chk("md req1_ready idle", 32'(req1_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("md hex_led represent", 32'(hex_led), 32'hFACADE);
      chk("md owner represent", 32'(owner), 32'h1);
      chk("md busy represent", 32'(busy), 32'h1);
      @(negedge clk);
      drive(1'b0, 24'h0, 1'b0, 24'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
